// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle between the operand registers and the BCD adder.
//   start, sub, addend, augend, carry_in : request side (driven by master)
//   busy, done, sum, carry_out, invalid,
//   seg                                  : result side (driven by slave)
// Digit i of addend/augend/sum sits at [4i+3:4i]; seg digit i at [7i+6:7i],
// bit order {g,f,e,d,c,b,a}, active high.
interface bcd_serial_adder_if #(
   parameter int DIGITS = 4
);
   logic                  start;
   logic                  sub;
   logic [4*DIGITS-1:0]   addend;
   logic [4*DIGITS-1:0]   augend;
   logic                  carry_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   sum;
   logic                  carry_out;
   logic                  invalid;
   logic [7*DIGITS-1:0]   seg;

   modport master (
      output start, sub, addend, augend, carry_in,
      input  busy, done, sum, carry_out, invalid, seg
   );

   modport slave (
      input  start, sub, addend, augend, carry_in,
      output busy, done, sum, carry_out, invalid, seg
   );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD add/subtract unit with registered seven-segment outputs.
// One digit per clock, least-significant first. Subtract uses the ten's
// complement (nine's complement of B plus an initial carry of 1).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_serial_adder_if (operands in, results out)
module bcd_serial_adder #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   bcd_serial_adder_if.slave   bus
);
   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nxt;

   logic [W-1:0]          a_q, b_q, res_q, sum_q;
   logic                  sub_q, carry_q, inv_pend_q;
   logic [3:0]            idx_q;
   logic                  co_q, inv_q, done_q;
   logic [7*DIGITS-1:0]   seg_q;

   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    seg_enc = 7'b0111111;
         4'd1:    seg_enc = 7'b0000110;
         4'd2:    seg_enc = 7'b1011011;
         4'd3:    seg_enc = 7'b1001111;
         4'd4:    seg_enc = 7'b1100110;
         4'd5:    seg_enc = 7'b1101101;
         4'd6:    seg_enc = 7'b1111101;
         4'd7:    seg_enc = 7'b0000111;
         4'd8:    seg_enc = 7'b1111111;
         4'd9:    seg_enc = 7'b1101111;
         default: seg_enc = 7'b0000000;
      endcase
   endfunction

   // Any non-BCD digit in the operands being latched poisons the whole result.
   logic inv_in;
   always_comb begin
      inv_in = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bus.addend[4*i +: 4] > 4'd9 || bus.augend[4*i +: 4] > 4'd9)
            inv_in = 1'b1;
      end
   end

   // Single-digit BCD stage for the digit selected by idx_q.
   logic [5:0]   shamt;
   logic [W-1:0] a_sh, b_sh, res_mask, res_ins;
   logic [3:0]   a_dig, b_dig, b_eff, dig_out;
   logic [4:0]   t;
   logic         c_out;
   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      shamt    = {idx_q, 2'b00};
      a_sh     = a_q >> shamt;
      b_sh     = b_q >> shamt;
      a_dig    = a_sh[3:0];
      b_dig    = b_sh[3:0];
      // 4-bit wrap of 9-b is intentional for out-of-range digits.
      b_eff    = sub_q ? (4'd9 - b_dig) : b_dig;
      t        = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
      dig_out  = t[3:0];
      c_out    = 1'b0;
      if (t > 5'd9) begin
         dig_out = 4'(t + 5'd6);
         c_out   = 1'b1;
      end
      res_mask = W'(4'hF) << shamt;
      res_ins  = (res_q & ~res_mask) | (W'(dig_out) << shamt);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (idx_q == 4'(DIGITS - 1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   logic [W-1:0] new_sum;
   assign new_sum = inv_pend_q ? '0 : res_q;

   // NOTE: the operand/result registers are reset as well, so an aborted
   // operation leaves no stale digits behind and outputs read blank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         res_q      <= '0;
         sub_q      <= 1'b0;
         carry_q    <= 1'b0;
         inv_pend_q <= 1'b0;
         idx_q      <= '0;
         sum_q      <= '0;
         co_q       <= 1'b0;
         inv_q      <= 1'b0;
         done_q     <= 1'b0;
         seg_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q        <= bus.addend;
                  b_q        <= bus.augend;
                  sub_q      <= bus.sub;
                  carry_q    <= bus.sub ? 1'b1 : bus.carry_in;
                  inv_pend_q <= inv_in;
                  idx_q      <= '0;
                  res_q      <= '0;
               end
            end
            RUN: begin
               res_q   <= res_ins;
               carry_q <= c_out;
               idx_q   <= idx_q + 4'd1;
            end
            DONE: begin
               done_q <= 1'b1;
               sum_q  <= new_sum;
               co_q   <= inv_pend_q ? 1'b0 : carry_q;
               inv_q  <= inv_pend_q;
               for (int i = 0; i < DIGITS; i++)
                  seg_q[7*i +: 7] <= seg_enc(new_sum[4*i +: 4]);
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state == RUN);
   assign bus.done      = done_q;
   assign bus.sum       = sum_q;
   assign bus.carry_out = co_q;
   assign bus.invalid   = inv_q;
   assign bus.seg       = seg_q;
endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Parametrised, multi-digit, digit-serial BCD add/subtract unit with registered seven-segment outputs.
- Successor to the single-digit combinational BCD adder: generalised to DIGITS digits, processed one digit per clock from the least-significant digit (LSD) upward.
- Adds a ten's-complement subtract mode, a start/busy/done handshake and invalid-digit detection.
- Sits between operand registers (switches/keypad) and the board's seven-segment display bank.

Parameters:
- DIGITS, default 4, number of BCD digits per operand (legal range 1..8).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request an operation; sampled only in IDLE
- sub  input  1  0 = addend+augend+carry_in; 1 = addend-augend
- addend  input  4*DIGITS  BCD operand A; digit i at [4i+3:4i]
- augend  input  4*DIGITS  BCD operand B, same packing
- carry_in  input  1  incoming decimal carry (add mode only)
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results update
- sum  output  4*DIGITS  BCD result, same packing
- carry_out  output  1  add mode: decimal overflow; sub mode: 1 = no borrow (A>=B)
- invalid  output  1  a latched operand digit was >9
- seg  output  7*DIGITS  segments for sum digit i at [7i+6:7i], bit order {g,f,e,d,c,b,a}, active high

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. rst_n low forces:
  - FSM to IDLE
  - busy=0, done=0, sum=0, carry_out=0, invalid=0
  - seg=0 (all segments blank)
  - internal operand/index/carry registers cleared
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch addend, augend and sub.
  - Digit index idx=0.
  - Initial carry = sub ? 1 : carry_in.
  - invalid_pending = OR over all latched digits of (digit>9).
  - Go to RUN.
  - busy=0 in IDLE.
- RUN (busy=1), one digit per cycle:
  - b' = sub ? (9 - b[idx]) : b[idx]; where b[idx]>9, b' uses the 4-bit wrap of 9-b.
  - t = a[idx] + b' + carry (5-bit).
  - If t>9: digit = t+6 (low 4 bits) and carry=1; else digit = t and carry=0.
  - Store the digit into an internal result register.
  - When idx=DIGITS-1, go to DONE; otherwise idx+1.
- DONE (busy=0), for exactly one cycle:
  - done=1.
  - If invalid_pending: sum=0, carry_out=0, invalid=1.
  - Otherwise: sum = internal result, carry_out = final carry, invalid=0.
  - Each seg digit is updated from the new sum digit.
  - Next state: IDLE.
- Latency: start sampled high at rising edge T gives done=1 in the cycle after edge T+DIGITS+1. Minimum start-to-start interval is DIGITS+2 cycles.
- sum, carry_out, invalid and seg hold their values between done pulses. They never show partial results.
- start while in RUN or DONE is ignored (not queued). Operand changes after the start sample have no effect on the operation in flight.
- Subtract with A<B: sum is the ten's complement (e.g. 0001-0002 = 9999) and carry_out=0.
- Seg encoding per digit {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Reset mid-operation: immediate abort. No done pulse, all outputs as at reset.

Test Plan:
- DIGITS=4, add 0007+0007, carry_in=1, start pulse at edge T -> busy high for 4 cycles, done pulse after edge T+5. Results: sum=0015, carry_out=0, invalid=0, seg digit0=1101101, digit1=0000110, digit2/3=0111111.
- Add 9999+0001, carry_in=0 -> sum=0000, carry_out=1. Then add 4567+5432, carry_in=1 -> sum=0000, carry_out=1.
- Subtract 0100-0001 -> sum=0099, carry_out=1. Then subtract 0001-0002 -> sum=9999, carry_out=0. carry_in=1 is ignored in both.
- Invalid: addend=00A3, augend=0001 -> done pulse with sum=0000, carry_out=0, invalid=1, seg all 0111111. A following valid 0002+0003 -> sum=0005, invalid=0.
- Handshake:
  - start held high continuously -> operations accepted only in IDLE, so done pulses every DIGITS+2 cycles.
  - start pulse in RUN with different operands -> ignored; result reflects the first operands.
- Reset: rst_n low for 1 cycle during the second RUN cycle of 1234+1111 -> busy=0, sum=0, seg=0 immediately, and no done pulse. A fresh start afterwards gives sum=2345.
